// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the F/D and D/E latches and the PC register.
// Detects decode RAW hazards, sequences multi-cycle mul/div occupancy of E,
// and sequences wrong-path flushes after a taken branch resolved in E.
// Optional feature macro: PIPE_FORWARD_EN (E/M->D forwarding present, so only
// load-use stalls). Without it, any in-flight E/M writer hit also stalls.
// Outputs are combinational from state + current inputs for zero-cycle reaction.
module pipeline_hazard_ctrl #(
  parameter int MD_LATENCY   = 8,
  parameter int FLUSH_CYCLES = 1,
  parameter int RW           = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [RW-1:0] dRs,
  input  logic [RW-1:0] dRt,
  input  logic          dUsesRs,
  input  logic          dUsesRt,
  input  logic [RW-1:0] eRd,
  input  logic          eRegWrite,
  input  logic          eMemRead,
  input  logic [RW-1:0] mRd,
  input  logic          mRegWrite,
  input  logic          eBranchTaken,
  input  logic          mdStart,
  output logic          pcStall,
  output logic          fdStall,
  output logic          fdFlush,
  output logic          deFlush,
  output logic          eStall,
  output logic          mdBusy
);

  typedef enum logic [1:0] {S_RUN, S_MD_WAIT, S_FLUSH} state_t;

  localparam logic [4:0] MD_RELOAD = 5'(MD_LATENCY - 2);
  localparam logic [4:0] FL_RELOAD = 5'(FLUSH_CYCLES - 1);

  state_t     r_state;
  logic [4:0] r_cnt;

  logic w_hit_e, w_hit_m, w_load_use, w_raw_stall;

  // Register 0 is hardwired, so it never creates a dependency
  assign w_hit_e = (eRd != '0) && ((dUsesRs && (dRs == eRd)) || (dUsesRt && (dRt == eRd)));
  assign w_hit_m = (mRd != '0) && ((dUsesRs && (dRs == mRd)) || (dUsesRt && (dRt == mRd)));
  assign w_load_use = eMemRead && eRegWrite && w_hit_e;

`ifdef PIPE_FORWARD_EN
  // Forwarding covers every E/M producer except a load still in E
  assign w_raw_stall = w_load_use;
`else
  // No forwarding: wait until the writer has left M (WB writes first half-cycle)
  assign w_raw_stall = w_load_use || (eRegWrite && w_hit_e) || (mRegWrite && w_hit_m);
`endif

  // Output decode: branch > mul/div start > hazard stalls; outputs forced low in reset
  always_comb begin
    pcStall = 1'b0;
    fdStall = 1'b0;
    fdFlush = 1'b0;
    deFlush = 1'b0;
    eStall  = 1'b0;
    mdBusy  = 1'b0;
    if (rst) begin
      unique case (r_state)
        S_RUN: begin
          if (eBranchTaken) begin
            // D instr is wrong-path, so flush instead of stalling it
            fdFlush = 1'b1;
            deFlush = 1'b1;
          end else if (mdStart) begin
            pcStall = 1'b1;
            fdStall = 1'b1;
            eStall  = 1'b1;
            mdBusy  = 1'b1;
          end else if (w_raw_stall) begin
            pcStall = 1'b1;
            fdStall = 1'b1;
            deFlush = 1'b1;
          end
        end
        S_MD_WAIT: begin
          // E frozen: hazards, branches and new starts are all ignored
          pcStall = 1'b1;
          fdStall = 1'b1;
          eStall  = 1'b1;
          mdBusy  = 1'b1;
        end
        S_FLUSH: begin
          fdFlush = 1'b1;
          deFlush = eBranchTaken;
        end
        default: ;
      endcase
    end
  end

  // State/counter sequencing; async active-low reset returns to RUN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_RUN: begin
          if (eBranchTaken) begin
            // Branch wins over a same-cycle mdStart, which is dropped
            if (FLUSH_CYCLES > 1) begin
              r_state <= S_FLUSH;
              r_cnt   <= FL_RELOAD;
            end
          end else if (mdStart) begin
            // Issue cycle counts as the first of MD_LATENCY
            r_state <= S_MD_WAIT;
            r_cnt   <= MD_RELOAD;
          end
        end
        S_MD_WAIT: begin
          if (r_cnt == 5'd0) r_state <= S_RUN;
          else               r_cnt   <= r_cnt - 5'd1;
        end
        S_FLUSH: begin
          // cnt holds the number of flush cycles still owed including this one
          if (eBranchTaken) begin
            r_cnt <= FL_RELOAD;
          end else if (r_cnt <= 5'd1) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        default: begin
          r_state <= S_RUN;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
